wide_bus_frame_arbiter: RTL and testbench



---
 rtl/wide_bus_arb_pkg.sv | 22 ++
 rtl/wfa_rr_picker.sv | 28 ++
 rtl/wide_bus_frame_arbiter.sv | 156 +++++++++++++++
 tb/tb_wide_bus_frame_arbiter.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/wide_bus_arb_pkg.sv
// wide_bus_arb_pkg: shared types and constants for wide_bus_frame_arbiter.
// FSM state encoding, default frame geometry, and the index-width helper
// used to size requester and beat indices.
package wide_bus_arb_pkg;

    // Arbiter FSM states; the encoding is also what dbg_state reports.
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_PRESENT = 2'd2
    } arb_state_t;

    localparam int BEAT_W_DEF      = 128;
    localparam int FRAME_BEATS_DEF = 8;
    localparam int FRAME_W_DEF     = BEAT_W_DEF * FRAME_BEATS_DEF;

    // Width needed to index n items, never less than one bit.
    function automatic int idx_w(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/wfa_rr_picker.sv
// wfa_rr_picker: combinational round-robin search.
// Returns the first set bit of i_req_vec found by searching upward from
// i_rr_ptr with wrap-around, plus a flag saying whether any bit was set.
module wfa_rr_picker
    import wide_bus_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = 2
) (
    input  logic [NUM_REQ-1:0] i_req_vec,
    input  logic [IDX_W-1:0]   i_rr_ptr,
    output logic               o_any_req,
    output logic [IDX_W-1:0]   o_winner
);

    // Walk offsets from farthest to nearest so the nearest set bit wins.
    always_comb begin
        o_any_req = 1'b0;
        o_winner  = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (i_req_vec[(int'(i_rr_ptr) + i) % NUM_REQ]) begin
                o_any_req = 1'b1;
                o_winner  = IDX_W'((int'(i_rr_ptr) + i) % NUM_REQ);
            end
        end
    end

endmodule

// File: rtl/wide_bus_frame_arbiter.sv
// wide_bus_frame_arbiter: round-robin arbiter that packs FRAME_BEATS beats
// from one granted requester into a FRAME_W-bit frame and presents it
// downstream. A stall timeout aborts a hung requester's partial frame.
// Optional build macro: WIDE_FRAME_PARITY_EN adds per-beat parity output
// frame_parity.
//
// Handshakes: a transfer happens on a rising edge where both valid and
// ready are high. Requester side: req_ready is one-hot to the granted
// requester only while collecting and does not depend on req_valid.
// Downstream side: frame_valid stays high with data and owner held stable
// until frame_ready is seen; frame_ready outside PRESENT is ignored.
module wide_bus_frame_arbiter
    import wide_bus_arb_pkg::*;
#(
    parameter int NUM_REQ     = 4,
    parameter int BEAT_W      = BEAT_W_DEF,
    parameter int FRAME_BEATS = FRAME_BEATS_DEF,
    parameter int TIMEOUT     = 15
) (
    input  logic                            main_clk_100mhz,
    input  logic                            reset,
    input  logic [NUM_REQ-1:0]              req_valid,
    input  logic [NUM_REQ*BEAT_W-1:0]       req_beat,
    output logic [NUM_REQ-1:0]              req_ready,
    output logic [BEAT_W*FRAME_BEATS-1:0]   frame_data,
    output logic                            frame_valid,
    input  logic                            frame_ready,
    output logic [idx_w(NUM_REQ)-1:0]       frame_owner,
    output logic                            abort_pulse,
    output logic                            busy,
`ifdef WIDE_FRAME_PARITY_EN
    output logic [FRAME_BEATS-1:0]          frame_parity,
`endif
    output logic [1:0]                      dbg_state
);

    localparam int FRAME_W = BEAT_W * FRAME_BEATS;
    localparam int IDX_W   = idx_w(NUM_REQ);
    localparam int CNT_W   = idx_w(FRAME_BEATS);
    localparam int STALL_W = idx_w(TIMEOUT + 1);

    arb_state_t          r_state;
    logic [IDX_W-1:0]    r_rr_ptr;
    logic [IDX_W-1:0]    r_grant;
    logic [CNT_W-1:0]    r_beat_cnt;
    logic [STALL_W-1:0]  r_stall_cnt;
    logic [FRAME_W-1:0]  r_frame_data;
    logic                r_abort;
`ifdef WIDE_FRAME_PARITY_EN
    logic [FRAME_BEATS-1:0] r_frame_parity;
`endif

    logic                w_any_req;
    logic [IDX_W-1:0]    w_winner;
    logic [BEAT_W-1:0]   w_beat;
    logic                w_accept;
    logic                w_last_beat;
    logic                w_timeout;
    logic [IDX_W-1:0]    w_rr_next;

    wfa_rr_picker #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_picker (
        .i_req_vec (req_valid),
        .i_rr_ptr  (r_rr_ptr),
        .o_any_req (w_any_req),
        .o_winner  (w_winner)
    );

    assign w_beat      = req_beat[r_grant*BEAT_W +: BEAT_W];
    assign w_accept    = (r_state == ST_COLLECT) && req_valid[r_grant];
    assign w_last_beat = (r_beat_cnt == CNT_W'(FRAME_BEATS - 1));
    // The abort fires on the stall cycle that would bring the count to TIMEOUT.
    assign w_timeout   = (TIMEOUT != 0) && (r_stall_cnt == STALL_W'(TIMEOUT - 1));
    assign w_rr_next   = (r_grant == IDX_W'(NUM_REQ - 1)) ? '0 : r_grant + IDX_W'(1);

    // Ready goes only to the granted requester, and only while collecting.
    always_comb begin
        req_ready = '0;
        if (r_state == ST_COLLECT) begin
            req_ready[r_grant] = 1'b1;
        end
    end

    assign frame_valid = (r_state == ST_PRESENT);
    assign busy        = (r_state != ST_IDLE);
    assign frame_data  = r_frame_data;
    assign frame_owner = r_grant;
    assign abort_pulse = r_abort;
    assign dbg_state   = r_state;
`ifdef WIDE_FRAME_PARITY_EN
    assign frame_parity = r_frame_parity;
`endif

    // FSM, beat packing, stall timer and round-robin pointer update.
    always_ff @(posedge main_clk_100mhz or posedge reset) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_rr_ptr     <= '0;
            r_grant      <= '0;
            r_beat_cnt   <= '0;
            r_stall_cnt  <= '0;
            r_frame_data <= '0;
            r_abort      <= 1'b0;
`ifdef WIDE_FRAME_PARITY_EN
            r_frame_parity <= '0;
`endif
        end else begin
            r_abort <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_any_req) begin
                        r_grant     <= w_winner;
                        r_beat_cnt  <= '0;
                        r_stall_cnt <= '0;
                        r_state     <= ST_COLLECT;
`ifdef WIDE_FRAME_PARITY_EN
                        r_frame_parity <= '0;
`endif
                    end
                end
                ST_COLLECT: begin
                    if (w_accept) begin
                        r_frame_data[r_beat_cnt*BEAT_W +: BEAT_W] <= w_beat;
`ifdef WIDE_FRAME_PARITY_EN
                        r_frame_parity[r_beat_cnt] <= ^w_beat;
`endif
                        r_beat_cnt  <= r_beat_cnt + CNT_W'(1);
                        r_stall_cnt <= '0;
                        if (w_last_beat) begin
                            r_state <= ST_PRESENT;
                        end
                    end else if (w_timeout) begin
                        // Partial frame is dropped; frame_data keeps whatever it held.
                        r_abort  <= 1'b1;
                        r_rr_ptr <= w_rr_next;
                        r_state  <= ST_IDLE;
                    end else if (r_stall_cnt != {STALL_W{1'b1}}) begin
                        r_stall_cnt <= r_stall_cnt + STALL_W'(1);
                    end
                end
                ST_PRESENT: begin
                    if (frame_ready) begin
                        r_rr_ptr <= w_rr_next;
                        r_state  <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wide_bus_frame_arbiter.sv
// tb_wide_bus_frame_arbiter: directed bench for wide_bus_frame_arbiter with
// default parameters (4 requesters, 128-bit beats, 8 beats, TIMEOUT 15).
// Build with WIDE_FRAME_PARITY_EN to include the parity sequence.
module tb_wide_bus_frame_arbiter;

  localparam int NR = 4;
  localparam int BW = 128;
  localparam int FB = 8;
  localparam int FW = BW * FB;

  // ---------------- clock / reset ----------------
  logic main_clk_100mhz = 1'b0;
  logic reset = 1'b1;
  always #5 main_clk_100mhz = ~main_clk_100mhz;

  logic [NR-1:0]    req_valid = '0;
  logic [NR*BW-1:0] req_beat = '0;
  logic [NR-1:0]    req_ready;
  logic [FW-1:0]    frame_data;
  logic             frame_valid;
  logic             frame_ready = 1'b0;
  logic [1:0]       frame_owner;
  logic             abort_pulse;
  logic             busy;
  logic [1:0]       dbg_state;
`ifdef WIDE_FRAME_PARITY_EN
  logic [FB-1:0]    frame_parity;
`endif

  wide_bus_frame_arbiter dut (
    .main_clk_100mhz (main_clk_100mhz),
    .reset           (reset),
    .req_valid       (req_valid),
    .req_beat        (req_beat),
    .req_ready       (req_ready),
    .frame_data      (frame_data),
    .frame_valid     (frame_valid),
    .frame_ready     (frame_ready),
    .frame_owner     (frame_owner),
    .abort_pulse     (abort_pulse),
    .busy            (busy),
`ifdef WIDE_FRAME_PARITY_EN
    .frame_parity    (frame_parity),
`endif
    .dbg_state       (dbg_state)
  );

  // ---------------- scoreboard state ----------------
  int total = 0;
  int bad = 0;
  logic [BW-1:0] exp_q[$];
  int beat_n[NR];
  int data_mode = 0;

  typedef struct {
    logic [NR-1:0] mask;
    int            exp_owner;
    int            exp_period;
  } vec_t;
  vec_t vecs[10];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // mode 0: plain count 1,2,3..; mode 1: tagged by requester; mode 2: alternating 0x1/0x3
  function automatic logic [BW-1:0] mk_beat(input int r, input int n);
    case (data_mode)
      0: return BW'(n + 1);
      1: return {8'(r + 1), 56'h0, 32'hC0DE_0000, 32'(n)};
      default: return ((n % 2) == 0) ? BW'(1) : BW'(3);
    endcase
  endfunction

  task automatic set_mode(input int m);
    data_mode = m;
    for (int r = 0; r < NR; r++) begin
      beat_n[r] = 0;
      req_beat[r*BW +: BW] = mk_beat(r, 0);
    end
  endtask

  // ---------------- driver ----------------
  // One clock: records what will be accepted at the coming edge, then
  // advances each accepting requester to its next beat.
  task automatic step();
    logic [NR-1:0] acc;
    acc = req_valid & req_ready;
    @(posedge main_clk_100mhz);
    #1;
    for (int r = 0; r < NR; r++) begin
      if (acc[r]) begin
        exp_q.push_back(req_beat[r*BW +: BW]);
        beat_n[r]++;
        req_beat[r*BW +: BW] = mk_beat(r, beat_n[r]);
      end
    end
    check("ready_onehot", 128'((req_ready & (req_ready - 4'd1)) == 4'd0), 128'd1);
  endtask

  task automatic wait_frame(output int edges);
    edges = 0;
    while (!frame_valid && edges < 40) begin
      step();
      edges++;
    end
  endtask

  task automatic check_frame(input string tag, input int exp_owner);
    logic [BW-1:0] e;
    check({tag, "_owner"}, 128'(frame_owner), 128'(exp_owner));
    check({tag, "_beats"}, 128'(exp_q.size()), 128'd8);
    for (int k = 0; k < FB; k++) begin
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check($sformatf("%s_beat%0d", tag, k), frame_data[k*BW +: BW], e);
      end
    end
    exp_q.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- test sequence ----------------
  initial begin
    int n;
    vecs[0] = '{4'b1111, 0, 10};
    vecs[1] = '{4'b1111, 1, 10};
    vecs[2] = '{4'b1111, 2, 10};
    vecs[3] = '{4'b1111, 3, 10};
    vecs[4] = '{4'b1111, 0, 10};
    vecs[5] = '{4'b0001, 0, 10};
    vecs[6] = '{4'b1000, 3, 10};
    vecs[7] = '{4'b0110, 1, 10};
    vecs[8] = '{4'b0101, 2, 10};
    vecs[9] = '{4'b0011, 0, 10};

    set_mode(0);
    #2;
    check("rst_busy", 128'(busy), 128'd0);
    check("rst_fvalid", 128'(frame_valid), 128'd0);
    check("rst_ready", 128'(req_ready), 128'd0);
    check("rst_abort", 128'(abort_pulse), 128'd0);
    check("rst_owner", 128'(frame_owner), 128'd0);
    check("rst_data_zero", 128'(|frame_data), 128'd0);
    check("rst_state", 128'(dbg_state), 128'd0);
    repeat (3) @(posedge main_clk_100mhz);
    #1;
    reset = 1'b0;

    // Single requester 1, beats 0x1..0x8, then a 20-cycle downstream stall.
    req_valid = 4'b0010;
    step();
    check("t1_busy", 128'(busy), 128'd1);
    check("t1_owner_at_grant", 128'(frame_owner), 128'd1);
    check("t1_ready", 128'(req_ready), 128'(4'b0010));
    wait_frame(n);
    check("t1_fvalid_edges", 128'(n + 1), 128'd9);
    req_valid = 4'b1000;
    check("t1_slice0", frame_data[127:0], 128'h1);
    check("t1_slice7", frame_data[1023:896], 128'h8);
    check_frame("t1", 1);
    for (int c = 0; c < 20; c++) begin
      step();
      check("t4_fvalid", 128'(frame_valid), 128'd1);
      check("t4_owner", 128'(frame_owner), 128'd1);
      check("t4_slice0", frame_data[127:0], 128'h1);
      check("t4_slice7", frame_data[1023:896], 128'h8);
      check("t4_ready", 128'(req_ready), 128'd0);
    end
    req_valid = 4'b0000;
    frame_ready = 1'b1;
    step();
    check("t4_release_fvalid", 128'(frame_valid), 128'd0);
    check("t4_release_busy", 128'(busy), 128'd0);
    frame_ready = 1'b0;

    // Requester 2 stalls after 3 beats; requester 3 requests meanwhile.
    set_mode(1);
    req_valid = 4'b0100;
    step();
    check("t3_owner", 128'(frame_owner), 128'd2);
    repeat (3) step();
    check("t3_partial_beats", 128'(exp_q.size()), 128'd3);
    req_valid = 4'b1000;
    n = 0;
    while (!abort_pulse && n < 40) begin
      step();
      n++;
      check("t3_no_fvalid", 128'(frame_valid), 128'd0);
    end
    check("t3_stall_cycles", 128'(n), 128'd15);
    check("t3_idle_after_abort", 128'(busy), 128'd0);
    exp_q.delete();
    req_valid = 4'b1100;
    step();
    check("t3_abort_one_cycle", 128'(abort_pulse), 128'd0);
    check("t3_next_owner", 128'(frame_owner), 128'd3);
    frame_ready = 1'b1;
    wait_frame(n);
    req_valid = 4'b0000;
    check_frame("t3b", 3);
    step();

    // Reset in the middle of a frame (after 5 beats of requester 2).
    frame_ready = 1'b0;
    req_valid = 4'b0100;
    step();
    repeat (5) step();
    check("t5_beats_before_rst", 128'(exp_q.size()), 128'd5);
    #3;
    reset = 1'b1;
    #1;
    check("t5_busy", 128'(busy), 128'd0);
    check("t5_fvalid", 128'(frame_valid), 128'd0);
    check("t5_ready", 128'(req_ready), 128'd0);
    check("t5_owner", 128'(frame_owner), 128'd0);
    check("t5_abort", 128'(abort_pulse), 128'd0);
    check("t5_data_zero", 128'(|frame_data), 128'd0);
    @(posedge main_clk_100mhz);
    #2;
    reset = 1'b0;
    exp_q.delete();

    // Table: round-robin order and back-to-back frame period.
    set_mode(1);
    frame_ready = 1'b1;
    for (int v = 0; v < 10; v++) begin
      req_valid = vecs[v].mask;
      wait_frame(n);
      check_frame($sformatf("vec%0d", v), vecs[v].exp_owner);
      step();
      check($sformatf("vec%0d_period", v), 128'(n + 1), 128'(vecs[v].exp_period));
    end
    req_valid = 4'b0000;
    frame_ready = 1'b0;
    step();
    check("tbl_idle", 128'(busy), 128'd0);

`ifdef WIDE_FRAME_PARITY_EN
    // Alternating 0x1 / 0x3 beats from requester 1 give parity 0x55.
    set_mode(2);
    req_valid = 4'b0010;
    wait_frame(n);
    req_valid = 4'b0000;
    check("par_bits", 128'(frame_parity), 128'(8'b01010101));
    check_frame("par", 1);
    frame_ready = 1'b1;
    step();
    frame_ready = 1'b0;
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
